// File: rtl/mips_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the Mini-MIPS core.
// Define MIPS_PERF_CNT_EN to build the cycle/instruction performance counters.
module mips_mc_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              reg_we,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_imm,
  output logic [1:0]        alu_op,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] cycle_cnt,
  output logic [ADDR_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic       illegal_q, illegal_d;

  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
  logic [1:0] pc_src_c, alu_op_c;
  logic       reg_we_c, reg_dst_c, mem_to_reg_c, alu_src_imm_c, halted_c;

  // funct is held for the datapath's ALU decoder; nothing here consumes it
  logic       unused_funct_q;
  assign unused_funct_q = ^funct_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    funct_d       = funct_q;
    illegal_d     = illegal_q;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_src_c      = 2'd0;
    reg_we_c      = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    alu_src_imm_c = 1'b0;
    alu_op_c      = 2'b00;
    halted_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Routing uses the live opcode; the latched copy is valid from EXEC on
        op_d    = op;
        funct_d = funct;
        case (op)
          OP_HALT: state_d = S_HALT;
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            alu_op_c = 2'b10;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_imm_c = 1'b1;
            state_d       = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_imm_c = 1'b1;
            state_d       = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c = 2'b01;
            pc_src_c = 2'd1;
            pc_we_c  = zero;
            state_d  = S_FETCH;
          end
          OP_J: begin
            pc_we_c  = 1'b1;
            pc_src_c = 2'd2;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (op_q == OP_SW);
        if (dmem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = (op_q == OP_RTYPE);
        mem_to_reg_c = (op_q == OP_LW);
        state_d      = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every control output at once so an outstanding request drops
  // without waiting for a clock edge.
  assign imem_req    = imem_req_c    & ~rst;
  assign dmem_req    = dmem_req_c    & ~rst;
  assign dmem_we     = dmem_we_c     & ~rst;
  assign ir_we       = ir_we_c       & ~rst;
  assign pc_we       = pc_we_c       & ~rst;
  assign pc_src      = rst ? 2'd0 : pc_src_c;
  assign reg_we      = reg_we_c      & ~rst;
  assign reg_dst     = reg_dst_c     & ~rst;
  assign mem_to_reg  = mem_to_reg_c  & ~rst;
  assign alu_src_imm = alu_src_imm_c & ~rst;
  assign alu_op      = rst ? 2'b00 : alu_op_c;
  assign halted      = halted_c      & ~rst;
  assign illegal     = illegal_q;
  assign state       = state_q;

`ifdef MIPS_PERF_CNT_EN
  logic [ADDR_W-1:0] cycle_q, cycle_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic              retire;

  always_comb begin
    retire  = ((state_d == S_FETCH) &&
               (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})) ||
              ((state_d == S_HALT) && (state_q != S_HALT));
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (state_q != S_HALT) cycle_d = cycle_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    if (retire)            instr_d = instr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed scenarios plus a randomized
// instruction stream checked cycle-by-cycle against a per-instruction model.
module tb_mips_mc_ctrl;

  localparam int unsigned ADDR_W = 32;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        op, funct;
  logic              zero, imem_ready, dmem_ready;
  logic              imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]        pc_src, alu_op;
  logic              reg_we, reg_dst, mem_to_reg, alu_src_imm;
  logic [2:0]        state;
  logic              halted, illegal;
  logic [ADDR_W-1:0] cycle_cnt, instr_cnt;

  mips_mc_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                reg_we, reg_dst, mem_to_reg, alu_src_imm, alu_op, halted, illegal};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc_m = 0;
  int unsigned icnt_m = 0;
  bit          ill_m = 1'b0;

  function automatic logic [16:0] mk(input int st, input int ireq, input int dreq,
                                      input int dwe, input int irwe, input int pcwe,
                                      input int psrc, input int rwe, input int rdst,
                                      input int m2r, input int asi, input int aop,
                                      input int hlt);
    return {3'(st), 1'(ireq), 1'(dreq), 1'(dwe), 1'(irwe), 1'(pcwe), 2'(psrc),
            1'(rwe), 1'(rdst), 1'(m2r), 1'(asi), 2'(aop), 1'(hlt)};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [ADDR_W-1:0] ec, ei;
`ifdef MIPS_PERF_CNT_EN
    ec = ADDR_W'(cyc_m);
    ei = ADDR_W'(icnt_m);
`else
    ec = '0;
    ei = '0;
`endif
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(ec));
    chk({tag, "_instr_cnt"}, 64'(instr_cnt), 64'(ei));
  endtask

  // Entered and left just after a falling edge.
  task automatic step(input bit ir, input bit dr, input bit z, input logic [5:0] o,
                      input logic [16:0] e, input bit retire, input string tag);
    imem_ready = ir;
    dmem_ready = dr;
    zero       = z;
    op         = o;
    funct      = rop();
    #1;
    chk(tag, 64'(obs), 64'({e, ill_m}));
    chk_cnt(tag);
    @(posedge clk);
    if (e[16:14] != 3'd5) cyc_m++;
    if (retire) icnt_m++;
    @(negedge clk);
  endtask

  // May be called at any time; returns just after a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    ill_m = 1'b0;
    cyc_m = 0;
    icnt_m = 0;
    chk(tag, 64'(obs), 64'(0));
    chk_cnt(tag);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_held"}, 64'(obs), 64'(0));
    rst = 1'b0;
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  task automatic run_instr(input logic [5:0] opc, input bit z,
                           input int unsigned iw, input int unsigned dw);
    bit st;
    st = (opc == OP_SW);
    for (int unsigned k = 0; k < iw; k++)
      step(1'b0, rb(), rb(), rop(), mk(0,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, "fetch_wait");
    step(1'b1, rb(), rb(), rop(), mk(0,1,0,0,1,1,0,0,0,0,0,0,0), 1'b0, "fetch_ready");
    if (opc == OP_HALT) begin
      step(rb(), rb(), rb(), opc, mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1, "decode_halt");
      return;
    end
    if (!is_legal(opc)) begin
      step(rb(), rb(), rb(), opc, mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b1, "decode_illegal");
      ill_m = 1'b1;
      return;
    end
    step(rb(), rb(), rb(), opc, mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, "decode");
    case (opc)
      OP_R: begin
        step(rb(), rb(), rb(), rop(), mk(2,0,0,0,0,0,0,0,0,0,0,2,0), 1'b0, "exec_r");
        step(rb(), rb(), rb(), rop(), mk(4,0,0,0,0,0,0,1,1,0,0,0,0), 1'b1, "wb_r");
      end
      OP_ADDI: begin
        step(rb(), rb(), rb(), rop(), mk(2,0,0,0,0,0,0,0,0,0,1,0,0), 1'b0, "exec_addi");
        step(rb(), rb(), rb(), rop(), mk(4,0,0,0,0,0,0,1,0,0,0,0,0), 1'b1, "wb_addi");
      end
      OP_LW, OP_SW: begin
        step(rb(), rb(), rb(), rop(), mk(2,0,0,0,0,0,0,0,0,0,1,0,0), 1'b0, "exec_mem");
        for (int unsigned k = 0; k < dw; k++)
          step(rb(), 1'b0, rb(), rop(), mk(3,0,1,st,0,0,0,0,0,0,0,0,0), 1'b0, "mem_wait");
        step(rb(), 1'b1, rb(), rop(), mk(3,0,1,st,0,0,0,0,0,0,0,0,0), st, "mem_ready");
        if (!st)
          step(rb(), rb(), rb(), rop(), mk(4,0,0,0,0,0,0,1,0,1,0,0,0), 1'b1, "wb_lw");
      end
      OP_BEQ:
        step(rb(), rb(), z, rop(), mk(2,0,0,0,0,z,1,0,0,0,0,1,0), 1'b1, "exec_beq");
      default:
        step(rb(), rb(), rb(), rop(), mk(2,0,0,0,0,1,2,0,0,0,0,0,0), 1'b1, "exec_j");
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] opc;
    logic [5:0] legal_ops [6];
    legal_ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    op = '0; funct = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

    do_reset("reset");

    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_SW, 1'b0, 2, 1);
    run_instr(6'b110000, 1'b0, 0, 0);
    chk("illegal_sticky", 64'(illegal), 64'(1));
    run_instr(OP_ADDI, 1'b0, 1, 0);
    chk("illegal_still_set", 64'(illegal), 64'(1));

    // reset while a data request is outstanding
    step(1'b1, 1'b0, 1'b0, rop(), mk(0,1,0,0,1,1,0,0,0,0,0,0,0), 1'b0, "fetch_pre_abort");
    step(1'b0, 1'b0, 1'b0, OP_SW, mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, "decode_pre_abort");
    step(1'b0, 1'b0, 1'b0, rop(), mk(2,0,0,0,0,0,0,0,0,0,1,0,0), 1'b0, "exec_pre_abort");
    step(1'b0, 1'b0, 1'b0, rop(), mk(3,0,1,1,0,0,0,0,0,0,0,0,0), 1'b0, "mem_pre_abort");
    dmem_ready = 1'b0;
    #2;
    do_reset("reset_mid_mem");
    chk("illegal_cleared", 64'(illegal), 64'(0));

    // perf counter scenario: j, addi, halt at zero wait
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_HALT, 1'b0, 0, 0);
    for (int unsigned k = 0; k < 12; k++)
      step(rb(), rb(), rb(), rop(), mk(5,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0, "halt_hold");
`ifdef MIPS_PERF_CNT_EN
    chk("perf_instr_cnt", 64'(instr_cnt), 64'(3));
    chk("perf_cycle_cnt", 64'(cycle_cnt), 64'(9));
`else
    chk("perf_instr_cnt_off", 64'(instr_cnt), 64'(0));
    chk("perf_cycle_cnt_off", 64'(cycle_cnt), 64'(0));
`endif
    #3;
    do_reset("reset_from_halt");
    chk("halted_cleared", 64'(halted), 64'(0));

    for (int unsigned n = 0; n < 150; n++) begin
      if ($urandom_range(0, 99) < 88) begin
        opc = legal_ops[$urandom_range(0, 5)];
      end else begin
        opc = rop();
        while (is_legal(opc) || opc == OP_HALT) opc = rop();
      end
      run_instr(opc, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_instr(OP_HALT, 1'b0, $urandom_range(0, 3), 0);
    for (int unsigned k = 0; k < 4; k++)
      step(rb(), rb(), rb(), rop(), mk(5,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0, "final_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the Mini-MIPS core. It drives the decoded instruction fields (`op`, `funct`) and the ALU `zero` flag through a FETCH/DECODE/EXEC/MEM/WB state machine. It generates every enable and mux select for the PC, instruction register, register file, ALU and data memory. It handles ready-based handshakes on both memory ports, and sits between the instruction decoder and the datapath.

## Interface
Parameters:
- `ADDR_W`, 32, width of performance counters (only used when counters compiled in)

Ports:
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous reset, active-high
- `op`  input  6  opcode from decoder
- `funct`  input  6  function field from decoder
- `zero`  input  1  ALU zero flag
- `imem_ready`  input  1  instruction memory has data this cycle
- `dmem_ready`  input  1  data memory completed access this cycle
- `imem_req`  output  1  instruction fetch request
- `dmem_req`  output  1  data memory request
- `dmem_we`  output  1  data memory write (valid with `dmem_req`)
- `ir_we`  output  1  load instruction register
- `pc_we`  output  1  update PC
- `pc_src`  output  2  0 = PC+4, 1 = branch target, 2 = jump target
- `reg_we`  output  1  register file write
- `reg_dst`  output  1  1 = write `rd`, 0 = write `rt`
- `mem_to_reg`  output  1  1 = writeback from memory, 0 = from ALU
- `alu_src_imm`  output  1  ALU operand B = sign-extended immediate
- `alu_op`  output  2  00 = add, 01 = sub, 10 = decode by funct
- `state`  output  3  current state encoding
- `halted`  output  1  core stopped
- `illegal`  output  1  sticky unknown-opcode flag
- `cycle_cnt`, `instr_cnt`  output  ADDR_W  performance counters

## Operation
- Opcodes: 000000 R-type, 001000 addi, 100011 lw, 101011 sw, 000100 beq, 000010 j, 111111 halt. Any other opcode is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: `imem_req`=1 held until `imem_ready`. In the ready cycle: `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE.
- DECODE: latch `op` and `funct` into internal registers. All later states use the latched values.
- DECODE → EXEC for every opcode except two cases:
  - halt → HALT.
  - illegal → set `illegal`, return to FETCH; the instruction is skipped, PC already advanced.
- EXEC, by instruction:
  - R-type: `alu_op`=10 → WB.
  - addi: `alu_src_imm`=1, `alu_op`=00 → WB.
  - lw/sw: `alu_src_imm`=1, `alu_op`=00 → MEM.
  - beq: `alu_op`=01, `pc_src`=1, `pc_we`=`zero` → FETCH.
  - j: `pc_we`=1, `pc_src`=2 → FETCH.
- MEM: `dmem_req`=1 held until `dmem_ready`; `dmem_we`=1 for sw. On ready: lw → WB, sw → FETCH.
- WB: `reg_we`=1 for one cycle. `reg_dst`=1 for R-type, 0 otherwise. `mem_to_reg`=1 for lw. Then → FETCH.
- HALT: absorbing state; only `rst` exits. `halted`=1.
- All control outputs are decoded combinationally from the state and latched op. Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH; `illegal`=0, `halted`=0, latched op/funct=0, counters=0. Reset is asynchronous and may assert mid-instruction, including with a memory request outstanding. The request drops immediately and no enable pulses.
- Latency in cycles with zero-wait memory (ready high in the first request cycle): R-type/addi 4, lw 5, sw 4, beq/j 3, illegal 2.
- Each cycle of ready low adds one cycle in FETCH or MEM. During wait cycles no enable is asserted except the held request.
- `ir_we` and `pc_we` in FETCH occur only in the `imem_ready` cycle.
- Changes on `op` after DECODE have no effect until the next DECODE.
- An `imem_ready` or `dmem_ready` pulse outside its matching request state is ignored.

## Configuration
- `MIPS_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle except in HALT.
  - `instr_cnt` increments on every return to FETCH from EXEC, MEM, WB or DECODE-illegal. It also increments once on entry to HALT.
  - Both counters wrap at 2^ADDR_W.
- `MIPS_PERF_CNT_EN` undefined: both ports are driven constant 0 and no counter flops exist.

## Test plan
- Reset, zero-wait memory, R-type add → states 0,1,2,4,0. `reg_we`=1 and `reg_dst`=1 only in the WB cycle; `pc_we`=1 once.
- lw with `dmem_ready` delayed 3 cycles → MEM held 4 cycles with `dmem_req`=1, `dmem_we`=0. Then WB with `mem_to_reg`=1; total 8 cycles.
- beq with zero=1, then with zero=0 → EXEC shows `pc_src`=1, with `pc_we`=1 and 0 respectively. Each instruction takes 3 cycles.
- Opcode 6'b110000 → `illegal` goes 1 and stays sticky, return to FETCH after 2 cycles, `reg_we` never asserted.
- Halt opcode, then `rst` pulse mid-stall → state=5 with `halted`=1 held for 10+ cycles. Async reset returns state 0 without a clock edge, and `halted` clears.
- With `MIPS_PERF_CNT_EN`: j, addi, halt sequence at zero-wait → `instr_cnt`=3, `cycle_cnt`=9 (3 j + 4 addi + 2 halt), frozen afterwards.
